spi_mem_ctrl: RTL and testbench

Memory-side stage of the rv32e CPU. It takes single load, store or instruction-fetch requests from the core and turns each into one SPI transaction on two external chips: flash/ROM on cs1 and SRAM on cs2. Received bytes are returned on fetched_instruction or fetched_data. The block holds request_done until the core drops start_request.

---
 rtl/rv32e_pkg.sv | 42 ++++
 rtl/spi_mem_ctrl_if.sv | 22 ++
 rtl/spi_shift_engine.sv | 68 ++++++
 rtl/spi_mem_ctrl.sv | 137 +++++++++++++
 tb/tb_spi_mem_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32e_pkg.sv
// Shared rv32e definitions: CPU opcodes, SPI flash/SRAM command bytes,
// memory-controller state encoding and received-data mapping helpers.
package rv32e_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, DONE} spi_state_t;

    function automatic logic size_ok(input logic [2:0] n);
        return (n == 3'd1) || (n == 3'd2) || (n == 3'd4);
    endfunction

    // Loads are big-endian within the transfer width, mirroring MSB-aligned stores.
    function automatic logic [31:0] map_load(input logic [31:0] rx, input logic [2:0] n);
        case (n)
            3'd1:    return {24'd0, rx[7:0]};
            3'd2:    return {16'd0, rx[15:0]};
            default: return rx;
        endcase
    endfunction

    // Fetches are little-endian: the first byte received lands in bits [7:0].
    function automatic logic [31:0] map_fetch(input logic [31:0] rx, input logic [2:0] n);
        case (n)
            3'd1:    return {24'd0, rx[7:0]};
            3'd2:    return {16'd0, rx[7:0], rx[15:8]};
            default: return {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
        endcase
    endfunction

endpackage

// File: rtl/spi_mem_ctrl_if.sv
// Core-side request/response bundle of the SPI memory controller.
interface spi_mem_ctrl_if;
    logic        start_request;
    logic        is_write;
    logic        is_data_fetch;
    logic [2:0]  num_bytes;
    logic [31:0] target_address;
    logic [31:0] write_value;
    logic [31:0] fetched_instruction;
    logic [31:0] fetched_data;
    logic        request_done;

    modport master (
        output start_request, is_write, is_data_fetch, num_bytes, target_address, write_value,
        input  fetched_instruction, fetched_data, request_done
    );

    modport slave (
        input  start_request, is_write, is_data_fetch, num_bytes, target_address, write_value,
        output fetched_instruction, fetched_data, request_done
    );
endinterface

// File: rtl/spi_shift_engine.sv
// MSB-first SPI mode-0 shifter: two clk cycles per bit, up to 32 bits per load.
// done_o flags the final bit's high phase so the next segment can load without a gap.
module spi_shift_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [5:0]  width_i,
    input  logic [31:0] tx_i,
    input  logic        miso_i,
    output logic        sclk_o,
    output logic        mosi_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] rx_o
);
    logic        busy_q, busy_d;
    logic        phase_q, phase_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] sh_q, sh_d;
    logic [31:0] rx_q, rx_d;

    always_comb begin
        busy_d  = busy_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        if (load_i) begin
            busy_d  = (width_i != 6'd0);
            phase_d = 1'b0;
            cnt_d   = width_i;
            sh_d    = tx_i;
            rx_d    = '0;
        end else if (busy_q) begin
            if (!phase_q) begin
                // Rising sclk: sample miso, which the slave set up during the low phase.
                phase_d = 1'b1;
                rx_d    = {rx_q[30:0], miso_i};
            end else begin
                phase_d = 1'b0;
                sh_d    = {sh_q[30:0], 1'b0};
                cnt_d   = cnt_q - 6'd1;
                if (cnt_q == 6'd1) busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            phase_q <= 1'b0;
            cnt_q   <= '0;
            rx_q    <= '0;
        end else begin
            busy_q  <= busy_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
        end
        sh_q <= sh_d;
    end

    assign sclk_o = busy_q & phase_q;
    assign mosi_o = busy_q & sh_q[31];
    assign busy_o = busy_q;
    assign done_o = busy_q & phase_q & (cnt_q == 6'd1);
    assign rx_o   = rx_q;
endmodule

// File: rtl/spi_mem_ctrl.sv
// Memory stage of the rv32e core: one SPI read/write per request to flash (cs1)
// or SRAM (cs2), sequencing command, address and data through the shift engine.
module spi_mem_ctrl
    import rv32e_pkg::*;
#(
    parameter int ADDR_BITS   = 24,
    parameter int DEV_SEL_BIT = 24
) (
    input  logic          clk,
    input  logic          rst,
    spi_mem_ctrl_if.slave bus,
    input  logic          miso,
    output logic          sclk,
    output logic          mosi,
    output logic          cs1,
    output logic          cs2
);
    spi_state_t state_q, state_d;
    logic                 cs1_q, cs1_d, cs2_q, cs2_d;
    logic [31:0]          instr_q, instr_d, data_q, data_d;
    logic                 wr_q, dfetch_q;
    logic [2:0]           nb_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [31:0]          wval_q;
    logic                 latch;

    logic        eng_load, eng_busy, eng_done;
    logic [5:0]  eng_width;
    logic [31:0] eng_tx, eng_rx;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^bus.target_address;

    spi_shift_engine u_engine (
        .clk     (clk),
        .rst     (rst),
        .load_i  (eng_load),
        .width_i (eng_width),
        .tx_i    (eng_tx),
        .miso_i  (miso),
        .sclk_o  (sclk),
        .mosi_o  (mosi),
        .busy_o  (eng_busy),
        .done_o  (eng_done),
        .rx_o    (eng_rx)
    );

    always_comb begin
        state_d   = state_q;
        cs1_d     = cs1_q;
        cs2_d     = cs2_q;
        instr_d   = instr_q;
        data_d    = data_q;
        latch     = 1'b0;
        eng_load  = 1'b0;
        eng_width = '0;
        eng_tx    = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_request && !eng_busy) begin
                    latch = 1'b1;
                    // Bad sizes and stores to flash complete at once with no bus traffic.
                    if (!size_ok(bus.num_bytes) || (bus.is_write && !bus.target_address[DEV_SEL_BIT])) begin
                        state_d = DONE;
                    end else begin
                        state_d   = CMD;
                        eng_load  = 1'b1;
                        eng_width = 6'd8;
                        eng_tx    = {(bus.is_write ? SPI_CMD_WRITE : SPI_CMD_READ), 24'd0};
                        cs1_d     = bus.target_address[DEV_SEL_BIT];
                        cs2_d     = !bus.target_address[DEV_SEL_BIT];
                    end
                end
            end
            CMD: begin
                if (eng_done) begin
                    state_d   = ADDR;
                    eng_load  = 1'b1;
                    eng_width = 6'(ADDR_BITS);
                    eng_tx    = 32'(addr_q) << (32 - ADDR_BITS);
                end
            end
            ADDR: begin
                if (eng_done) begin
                    state_d   = DATA;
                    eng_load  = 1'b1;
                    eng_width = {nb_q, 3'b000};
                    eng_tx    = wr_q ? wval_q : 32'd0;
                end
            end
            DATA: begin
                if (eng_done) begin
                    state_d = DONE;
                    cs1_d   = 1'b1;
                    cs2_d   = 1'b1;
                    if (!wr_q) begin
                        if (dfetch_q) data_d  = map_load(eng_rx, nb_q);
                        else          instr_d = map_fetch(eng_rx, nb_q);
                    end
                end
            end
            DONE: begin
                if (!bus.start_request) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cs1_q   <= 1'b1;
            cs2_q   <= 1'b1;
            instr_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cs1_q   <= cs1_d;
            cs2_q   <= cs2_d;
            instr_q <= instr_d;
            data_q  <= data_d;
        end
        if (latch) begin
            wr_q     <= bus.is_write;
            dfetch_q <= bus.is_data_fetch;
            nb_q     <= bus.num_bytes;
            addr_q   <= bus.target_address[ADDR_BITS-1:0];
            wval_q   <= bus.write_value;
        end
    end

    assign cs1                     = cs1_q;
    assign cs2                     = cs2_q;
    assign bus.fetched_instruction = instr_q;
    assign bus.fetched_data        = data_q;
    assign bus.request_done        = (state_q == DONE);
endmodule

// File: tb/tb_spi_mem_ctrl.sv
// Directed bench for spi_mem_ctrl with behavioural SPI flash and SRAM slaves.
// Table-driven requests plus hand-written hold-after-done and mid-transfer reset sequences.
module tb_spi_mem_ctrl;
    logic clk;
    logic rst;
    logic miso;
    logic sclk, mosi, cs1, cs2;

    spi_mem_ctrl_if bus();

    spi_mem_ctrl dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .miso (miso),
        .sclk (sclk),
        .mosi (mosi),
        .cs1  (cs1),
        .cs2  (cs2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // SPI slave models, observed on the falling clk edge.
    logic [7:0]  flash_mem [256];
    logic [7:0]  sram_mem  [256];
    int          m_bitcnt, m_rises, m_cs1_low, m_cs2_low, m_both_low, m_txns;
    logic        m_in_txn, m_prev_sclk, m_dev2;
    logic [7:0]  m_cmd, last_cmd;
    logic [23:0] m_addr, last_addr;
    logic [31:0] m_dsh, last_data;

    initial begin
        int idx;
        logic [7:0] byte_v;
        for (int k = 0; k < 256; k++) begin
            flash_mem[k] = 8'h00;
            sram_mem[k]  = 8'h00;
        end
        flash_mem[8'h10] = 8'h13;
        flash_mem[8'h11] = 8'h05;
        flash_mem[8'h12] = 8'h50;
        flash_mem[8'h13] = 8'h00;
        sram_mem[8'h04]  = 8'h80;
        sram_mem[8'h22]  = 8'h12;
        sram_mem[8'h23]  = 8'h34;
        miso = 1'b0;
        m_bitcnt = 0; m_rises = 0; m_cs1_low = 0; m_cs2_low = 0; m_both_low = 0; m_txns = 0;
        m_in_txn = 1'b0; m_prev_sclk = 1'b0; m_dev2 = 1'b0;
        m_cmd = '0; m_addr = '0; m_dsh = '0;
        last_cmd = '0; last_addr = '0; last_data = '0;
        forever begin
            @(negedge clk);
            if (!cs1) m_cs1_low++;
            if (!cs2) m_cs2_low++;
            if (!cs1 && !cs2) m_both_low++;
            if (sclk && !m_prev_sclk) m_rises++;
            if (!cs1 || !cs2) begin
                if (!m_in_txn) begin
                    m_in_txn = 1'b1;
                    m_bitcnt = 0;
                    m_cmd = '0; m_addr = '0; m_dsh = '0;
                    m_dev2 = !cs2;
                end
                if (sclk && !m_prev_sclk) begin
                    if (m_bitcnt < 8) m_cmd = {m_cmd[6:0], mosi};
                    else if (m_bitcnt < 32) m_addr = {m_addr[22:0], mosi};
                    else begin
                        m_dsh = {m_dsh[30:0], mosi};
                        if ((m_bitcnt % 8) == 7 && m_dev2 && m_cmd == 8'h02) begin
                            idx = (int'(m_addr[7:0]) + (m_bitcnt - 32) / 8) % 256;
                            sram_mem[idx] = m_dsh[7:0];
                        end
                    end
                    m_bitcnt++;
                end else if (!sclk && m_prev_sclk && m_bitcnt >= 32 && m_cmd == 8'h03) begin
                    idx = (int'(m_addr[7:0]) + (m_bitcnt - 32) / 8) % 256;
                    byte_v = m_dev2 ? sram_mem[idx] : flash_mem[idx];
                    miso = byte_v[7 - ((m_bitcnt - 32) % 8)];
                end
            end else begin
                if (m_in_txn) begin
                    m_in_txn  = 1'b0;
                    last_cmd  = m_cmd;
                    last_addr = m_addr;
                    last_data = m_dsh;
                    m_txns++;
                end
                miso = 1'b0;
            end
            m_prev_sclk = sclk;
        end
    end

    int checks, errors;
    int s_rises, s_cs1, s_cs2, s_both, s_txns;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic snapshot();
        s_rises = m_rises; s_cs1 = m_cs1_low; s_cs2 = m_cs2_low; s_both = m_both_low; s_txns = m_txns;
    endtask

    // Launches a request, returns edges from the start edge until request_done (start held high).
    task automatic do_req(input logic w, input logic df, input logic [2:0] nb,
                          input logic [31:0] a, input logic [31:0] wv, output int lat);
        @(posedge clk); #1;
        snapshot();
        bus.is_write = w; bus.is_data_fetch = df; bus.num_bytes = nb;
        bus.target_address = a; bus.write_value = wv; bus.start_request = 1'b1;
        @(posedge clk);
        lat = 1;
        #1;
        bus.is_write = ~w; bus.is_data_fetch = ~df; bus.num_bytes = 3'd3;
        bus.target_address = ~a; bus.write_value = ~wv;
        while (bus.request_done !== 1'b1 && lat < 400) begin
            @(posedge clk);
            lat++;
            #1;
        end
        @(negedge clk); #1;
    endtask

    task automatic release_req(input string name);
        bus.start_request = 1'b0;
        @(posedge clk); #1;
        check({name, " done low"}, 32'(bus.request_done), 32'd0);
    endtask

    typedef struct packed {
        logic        w;
        logic        df;
        logic [2:0]  nb;
        logic [31:0] addr;
        logic [31:0] wv;
        logic [8:0]  lat;
        logic [1:0]  cs;
        logic [31:0] instr;
        logic [31:0] data;
        logic [31:0] txd;
    } vec_t;

    vec_t vecs [14];

    initial begin
        int lat, k, ecycles;
        string nm;
        rst = 1'b1;
        bus.start_request = 1'b0; bus.is_write = 1'b0; bus.is_data_fetch = 1'b0;
        bus.num_bytes = 3'd0; bus.target_address = '0; bus.write_value = '0;
        checks = 0; errors = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset sclk", 32'(sclk), 32'd0);
        check("reset mosi", 32'(mosi), 32'd0);
        check("reset cs1", 32'(cs1), 32'd1);
        check("reset cs2", 32'(cs2), 32'd1);
        check("reset done", 32'(bus.request_done), 32'd0);
        check("reset instr", bus.fetched_instruction, 32'd0);
        check("reset data", bus.fetched_data, 32'd0);
        rst = 1'b0;

        //           w     df    nb    addr          wv            lat     cs    instr         data          txd
        vecs[0]  = '{1'b0, 1'b0, 3'd4, 32'h0000_0010, 32'h0,        9'd129, 2'd1, 32'h0050_0513, 32'h0,        32'h0};
        vecs[1]  = '{1'b0, 1'b1, 3'd1, 32'h0100_0004, 32'h0,        9'd81,  2'd2, 32'h0050_0513, 32'h0000_0080, 32'h0};
        vecs[2]  = '{1'b1, 1'b1, 3'd2, 32'h0100_0020, 32'hBEEF_0000, 9'd97, 2'd2, 32'h0050_0513, 32'h0000_0080, 32'h0000_BEEF};
        vecs[3]  = '{1'b0, 1'b1, 3'd2, 32'h0100_0020, 32'h0,        9'd97,  2'd2, 32'h0050_0513, 32'h0000_BEEF, 32'h0};
        vecs[4]  = '{1'b1, 1'b0, 3'd1, 32'h0000_0100, 32'h1100_0000, 9'd1,  2'd0, 32'h0050_0513, 32'h0000_BEEF, 32'h0};
        vecs[5]  = '{1'b0, 1'b0, 3'd3, 32'h0000_0010, 32'h0,        9'd1,   2'd0, 32'h0050_0513, 32'h0000_BEEF, 32'h0};
        vecs[6]  = '{1'b0, 1'b0, 3'd2, 32'h0000_0010, 32'h0,        9'd97,  2'd1, 32'h0000_0513, 32'h0000_BEEF, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, 3'd4, 32'h0100_0020, 32'h0,        9'd129, 2'd2, 32'h0000_0513, 32'hBEEF_1234, 32'h0};
        vecs[8]  = '{1'b0, 1'b0, 3'd1, 32'h0000_0012, 32'h0,        9'd81,  2'd1, 32'h0000_0050, 32'hBEEF_1234, 32'h0};
        vecs[9]  = '{1'b1, 1'b0, 3'd4, 32'h0100_0040, 32'hDEAD_BEEF, 9'd129, 2'd2, 32'h0000_0050, 32'hBEEF_1234, 32'hDEAD_BEEF};
        vecs[10] = '{1'b0, 1'b1, 3'd4, 32'h0100_0040, 32'h0,        9'd129, 2'd2, 32'h0000_0050, 32'hDEAD_BEEF, 32'h0};
        vecs[11] = '{1'b0, 1'b0, 3'd4, 32'h0100_0040, 32'h0,        9'd129, 2'd2, 32'hEFBE_ADDE, 32'hDEAD_BEEF, 32'h0};
        vecs[12] = '{1'b0, 1'b1, 3'd0, 32'h0100_0000, 32'h0,        9'd1,   2'd0, 32'hEFBE_ADDE, 32'hDEAD_BEEF, 32'h0};
        vecs[13] = '{1'b0, 1'b1, 3'd7, 32'h0100_0000, 32'h0,        9'd1,   2'd0, 32'hEFBE_ADDE, 32'hDEAD_BEEF, 32'h0};

        for (int i = 0; i < 14; i++) begin
            nm = $sformatf("v%0d", i);
            do_req(vecs[i].w, vecs[i].df, vecs[i].nb, vecs[i].addr, vecs[i].wv, lat);
            ecycles = int'(vecs[i].lat) - 1;
            check({nm, " latency"}, 32'(lat), 32'(vecs[i].lat));
            check({nm, " done"}, 32'(bus.request_done), 32'd1);
            check({nm, " instr"}, bus.fetched_instruction, vecs[i].instr);
            check({nm, " data"}, bus.fetched_data, vecs[i].data);
            check({nm, " cs1 low cycles"}, 32'(m_cs1_low - s_cs1), (vecs[i].cs == 2'd1) ? 32'(ecycles) : 32'd0);
            check({nm, " cs2 low cycles"}, 32'(m_cs2_low - s_cs2), (vecs[i].cs == 2'd2) ? 32'(ecycles) : 32'd0);
            check({nm, " both cs low"}, 32'(m_both_low - s_both), 32'd0);
            check({nm, " sclk rises"}, 32'(m_rises - s_rises), 32'(ecycles / 2));
            check({nm, " transactions"}, 32'(m_txns - s_txns), (vecs[i].cs != 2'd0) ? 32'd1 : 32'd0);
            if (vecs[i].cs != 2'd0) begin
                check({nm, " cmd"}, 32'(last_cmd), vecs[i].w ? 32'h02 : 32'h03);
                check({nm, " addr"}, 32'(last_addr), 32'(vecs[i].addr[23:0]));
                check({nm, " mosi data"}, last_data, vecs[i].txd);
            end
            release_req(nm);
        end

        // Hold start high after completion: no new traffic, done stays up.
        do_req(1'b0, 1'b0, 3'd1, 32'h0000_0010, 32'h0, lat);
        check("hold latency", 32'(lat), 32'd81);
        check("hold instr", bus.fetched_instruction, 32'h0000_0013);
        snapshot();
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("hold done c%0d", c), 32'(bus.request_done), 32'd1);
        end
        check("hold sclk rises", 32'(m_rises - s_rises), 32'd0);
        check("hold cs low", 32'(m_cs1_low - s_cs1 + m_cs2_low - s_cs2), 32'd0);
        release_req("hold");
        do_req(1'b0, 1'b0, 3'd4, 32'h0000_0010, 32'h0, lat);
        check("reraise latency", 32'(lat), 32'd129);
        check("reraise instr", bus.fetched_instruction, 32'h0050_0513);
        release_req("reraise");

        // Reset in the middle of a read, at bit 20.
        @(posedge clk); #1;
        bus.is_write = 1'b0; bus.is_data_fetch = 1'b0; bus.num_bytes = 3'd4;
        bus.target_address = 32'h0000_0010; bus.write_value = '0; bus.start_request = 1'b1;
        k = 0;
        while (m_bitcnt != 20 && k < 300) begin
            @(posedge clk); k++; #1;
        end
        check("abort reached bit 20", 32'(m_bitcnt), 32'd20);
        check("abort cs1 active", 32'(cs1), 32'd0);
        rst = 1'b1;
        bus.start_request = 1'b0;
        @(posedge clk); @(negedge clk);
        check("abort cs1", 32'(cs1), 32'd1);
        check("abort cs2", 32'(cs2), 32'd1);
        check("abort sclk", 32'(sclk), 32'd0);
        check("abort mosi", 32'(mosi), 32'd0);
        check("abort done", 32'(bus.request_done), 32'd0);
        check("abort instr", bus.fetched_instruction, 32'd0);
        check("abort data", bus.fetched_data, 32'd0);
        rst = 1'b0;
        do_req(1'b0, 1'b0, 3'd4, 32'h0000_0010, 32'h0, lat);
        check("post-reset latency", 32'(lat), 32'd129);
        check("post-reset instr", bus.fetched_instruction, 32'h0050_0513);
        check("post-reset data", bus.fetched_data, 32'd0);
        release_req("post-reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
